// File: rtl/checker_pkg.sv
// Shared state encoding, failure codes and sizing helper for regfile_trace_checker.
package checker_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_MISMATCH = 2'd1;
   localparam logic [1:0] FC_TIMEOUT  = 2'd2;
   localparam logic [1:0] FC_X0       = 2'd3;

   // A one-entry table still needs a 1-bit index.
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/trace_expect_table.sv
// Expected (reg, value) table: synchronous write port, asynchronous read by index.
module trace_expect_table #(
   parameter int unsigned NUM_CHECKS = 8,
   parameter int unsigned RADDR_W    = 5,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned IDX_W      = 3
) (
   input  logic               clk,
   input  logic               we,
   input  logic [IDX_W-1:0]   widx,
   input  logic [RADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [IDX_W-1:0]   ridx,
   output logic [RADDR_W-1:0] raddr,
   output logic [DATA_W-1:0]  rdata
);

   logic [RADDR_W+DATA_W-1:0] mem [NUM_CHECKS];

   always_ff @(posedge clk) begin
      if (we) mem[widx] <= {waddr, wdata};
   end

   assign {raddr, rdata} = mem[ridx];

endmodule

// File: rtl/regfile_trace_checker.sv
// Snoops register-file writes and checks them in order against a loaded table.
// Optional feature: define CHECKER_X0_CHECK_EN to flag nonzero writes to x0 as failures.
module regfile_trace_checker
   import checker_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned RADDR_W    = 5,
   parameter int unsigned NUM_CHECKS = 8,
   parameter int unsigned MAX_CYCLES = 64,
   localparam int unsigned IDX_W = idx_width(NUM_CHECKS),
   localparam int unsigned NE_W  = $clog2(NUM_CHECKS + 1),
   localparam int unsigned CC_W  = $clog2(MAX_CYCLES + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ld_en,
   input  logic [IDX_W-1:0]   ld_idx,
   input  logic [RADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0]  ld_data,
   input  logic [NE_W-1:0]    num_exp,
   input  logic               start,
   input  logic               wb_en,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [1:0]         fail_code,
   output logic [IDX_W-1:0]   fail_idx,
   output logic [DATA_W-1:0]  fail_data,
   output logic [CC_W-1:0]    cycle_cnt
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NE_W-1:0]    num_q, num_d;
   logic [CC_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [1:0]         code_q, code_d;
   logic [IDX_W-1:0]   fidx_q, fidx_d;
   logic [DATA_W-1:0]  fdata_q, fdata_d;
   logic [RADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0]  exp_data;
   logic               snoop, hit, last, x0_bad;

   trace_expect_table #(
      .NUM_CHECKS (NUM_CHECKS),
      .RADDR_W    (RADDR_W),
      .DATA_W     (DATA_W),
      .IDX_W      (IDX_W)
   ) u_table (
      .clk   (clk),
      .we    (ld_en && (state_q != RUN)),
      .widx  (ld_idx),
      .waddr (ld_addr),
      .wdata (ld_data),
      .ridx  (idx_q),
      .raddr (exp_addr),
      .rdata (exp_data)
   );

   assign snoop   = wb_en && (wb_addr != '0);
   assign hit     = (wb_addr == exp_addr) && (wb_data == exp_data);
   assign last    = (NE_W'(idx_q) == num_q - NE_W'(1));
   assign cnt_inc = (cnt_q == CC_W'(MAX_CYCLES)) ? cnt_q : cnt_q + CC_W'(1);

`ifdef CHECKER_X0_CHECK_EN
   assign x0_bad = wb_en && (wb_addr == '0) && (wb_data != '0);
`else
   assign x0_bad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      fidx_d  = fidx_q;
      fdata_d = fdata_q;
      unique case (state_q)
         RUN: begin
            cnt_d = cnt_inc;
            if (x0_bad) begin
               state_d = FAIL;
               code_d  = FC_X0;
               fidx_d  = idx_q;
               fdata_d = wb_data;
            end else if (snoop) begin
               if (hit) begin
                  if (last) state_d = PASS;
                  else      idx_d   = idx_q + IDX_W'(1);
               end else begin
                  state_d = FAIL;
                  code_d  = FC_MISMATCH;
                  fidx_d  = idx_q;
                  fdata_d = wb_data;
               end
            end
            // Timeout only applies when this cycle made no decision of its own.
            if ((state_d == RUN) && (cnt_inc == CC_W'(MAX_CYCLES))) begin
               state_d = FAIL;
               code_d  = FC_TIMEOUT;
               fidx_d  = idx_d;
               fdata_d = '0;
            end
         end
         default: begin
            if (start) begin
               num_d   = num_exp;
               idx_d   = '0;
               cnt_d   = '0;
               code_d  = FC_NONE;
               fidx_d  = '0;
               fdata_d = '0;
               state_d = (num_exp == '0) ? PASS : RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
         code_q  <= FC_NONE;
         fidx_q  <= '0;
         fdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         fidx_q  <= fidx_d;
         fdata_q <= fdata_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == PASS) || (state_q == FAIL);
   assign pass      = (state_q == PASS);
   assign fail_code = code_q;
   assign fail_idx  = fidx_q;
   assign fail_data = fdata_q;
   assign cycle_cnt = cnt_q;

endmodule
